// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencing for the 5-stage pipeline (load-use bubble, branch flush, memory freeze)
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   idex_memRead, idex_writeReg   load destination currently in ID/EX
//   ifid_rs1/rs2, ifid_use_rs1/2  source operands of the instruction in IF/ID
//   exmem_branch_taken            taken branch resolved in EX/MEM
//   exmem_memAccess, dmem_ready   memory access in EX/MEM and its completion
//   pc_write .. exmem_write       stage enables
//   ifid_flush, idex_flush        stage squash controls
//   stall_count, flush_count      saturating performance counters
//   mem_timeout                   sticky memory-wait timeout flag
module pipeline_hazard_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memRead,
    input  logic [4:0]       idex_writeReg,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs1,
    input  logic             ifid_use_rs2,
    input  logic             exmem_branch_taken,
    input  logic             exmem_memAccess,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt;
    logic          mem_busy, load_use, go;

    always_comb begin
        mem_busy    = exmem_memAccess & ~dmem_ready;
        load_use    = idex_memRead & (idex_writeReg != 5'd0) &
                      ((ifid_use_rs1 & (ifid_rs1 == idex_writeReg)) |
                       (ifid_use_rs2 & (ifid_rs2 == idex_writeReg)));
        // go: pipeline is neither in reset nor frozen on memory
        go          = ~rst & ~mem_busy;
        state_nx    = mem_busy ? MEM_WAIT : RUN;
        // a taken branch squashes the load-use consumer, so it overrides the bubble
        pc_write    = go & (exmem_branch_taken | ~load_use);
        ifid_write  = go & (exmem_branch_taken | ~load_use);
        idex_write  = go;
        exmem_write = go;
        ifid_flush  = go & exmem_branch_taken;
        idex_flush  = go & (exmem_branch_taken | load_use);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
            flush_count <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nx;
            wait_cnt <= !mem_busy ? WW'(0) :
                        state == RUN ? WW'(1) :
                        wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + WW'(1);
            if (state == MEM_WAIT && mem_busy && wait_cnt == WW'(MAX_WAIT))
                mem_timeout <= 1'b1;
            if (!pc_write && !(&stall_count))
                stall_count <= stall_count + 1'b1;
            if (ifid_flush && !(&flush_count))
                flush_count <= flush_count + 1'b1;
        end
    end
endmodule
